// File: rtl/ccl_neighbour_window.sv
// Causal 2x3 label neighbourhood generator for connected components labeling.
// Stores the labeler's output in a one-row line buffer so the next row can see it.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module ccl_neighbour_window #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [`WORD_SIZE-1:0] pixel_in,
  input  logic [`WORD_SIZE-1:0] label_in,
  output logic [`WORD_SIZE-1:0] A,
  output logic [`WORD_SIZE-1:0] B,
  output logic [`WORD_SIZE-1:0] C,
  output logic [`WORD_SIZE-1:0] D,
  output logic [`WORD_SIZE-1:0] data,
  output logic [31:0]           x,
  output logic [31:0]           y,
  output logic                  row_done,
  output logic                  frame_done
);

  localparam int          XW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [31:0] X_LAST = 32'(IMG_WIDTH - 1);
  localparam logic [31:0] Y_LAST = 32'(IMG_HEIGHT - 1);

  logic [`WORD_SIZE-1:0] row_buf [0:IMG_WIDTH-1];
  logic [`WORD_SIZE-1:0] a_reg;
  logic [`WORD_SIZE-1:0] d_reg;
  logic [XW-1:0]         cur_idx;
  logic [XW-1:0]         nxt_idx;
  logic                  first_row;
  logic                  first_col;
  logic                  last_col;

  assign first_row = (y == 32'd0);
  assign first_col = (x == 32'd0);
  assign last_col  = (x == X_LAST);
  assign cur_idx   = x[XW-1:0];
  // On the last column the right-hand read is steered to entry 0 so it stays in range.
  assign nxt_idx   = last_col ? '0 : cur_idx + XW'(1);

  assign B    = first_row ? '0 : row_buf[cur_idx];
  assign C    = (first_row || last_col) ? '0 : row_buf[nxt_idx];
  assign A    = (first_row || first_col) ? '0 : a_reg;
  assign D    = first_col ? '0 : d_reg;
  assign data = pixel_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      x          <= 32'd0;
      y          <= 32'd0;
      a_reg      <= '0;
      d_reg      <= '0;
      row_done   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      row_done   <= 1'b0;
      frame_done <= 1'b0;
      if (en) begin
        // a_reg takes the pre-write previous-row label, which becomes A at x+1.
        row_buf[cur_idx] <= label_in;
        a_reg            <= row_buf[cur_idx];
        d_reg            <= label_in;
        if (x < X_LAST) begin
          x <= x + 32'd1;
        end else begin
          x        <= 32'd0;
          row_done <= 1'b1;
          if (y < Y_LAST) begin
            y <= y + 32'd1;
          end else begin
            y          <= 32'd0;
            frame_done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ccl_neighbour_window.sv
// Self-checking bench for ccl_neighbour_window: directed vector table, hand-written
// corner sequences and a randomized run checked against a whole-frame label model.
module tb_ccl_neighbour_window;

  localparam int W = 4;
  localparam int H = 3;

  logic        clk;
  logic        reset;
  logic        en;
  logic [7:0]  pixel_in;
  logic [7:0]  label_in;
  logic [7:0]  A, B, C, D, data;
  logic [31:0] x, y;
  logic        row_done, frame_done;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: frame position, every label written so far, and pending pulses.
  int         mx, my;
  logic [7:0] lab [0:H-1][0:W-1];
  bit         m_rd, m_fd;

  typedef struct {
    bit         r, e;
    logic [7:0] pix, lbl;
    int         ex, ey;
    logic [7:0] ea, eb, ec, ed;
    bit         erd, efd;
  } vec_t;

  vec_t tbl [14];

  ccl_neighbour_window #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .en(en), .pixel_in(pixel_in), .label_in(label_in),
    .A(A), .B(B), .C(C), .D(D), .data(data), .x(x), .y(y),
    .row_done(row_done), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  function automatic vec_t mk(bit r, bit e, logic [7:0] pix, logic [7:0] lbl, int ex, int ey,
                              logic [7:0] ea, logic [7:0] eb, logic [7:0] ec, logic [7:0] ed,
                              bit erd, bit efd);
    vec_t v;
    v.r = r; v.e = e; v.pix = pix; v.lbl = lbl; v.ex = ex; v.ey = ey;
    v.ea = ea; v.eb = eb; v.ec = ec; v.ed = ed; v.erd = erd; v.efd = efd;
    return v;
  endfunction

  task automatic cmp(input string tag, input string fld, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s.%s got=%0h expected=%0h", tag, fld, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input int ex, input int ey,
                             input logic [7:0] ea, input logic [7:0] eb,
                             input logic [7:0] ec, input logic [7:0] ed,
                             input logic [7:0] edat, input bit erd, input bit efd);
    cmp(tag, "x", x, 32'(ex));
    cmp(tag, "y", y, 32'(ey));
    cmp(tag, "A", 32'(A), 32'(ea));
    cmp(tag, "B", 32'(B), 32'(eb));
    cmp(tag, "C", 32'(C), 32'(ec));
    cmp(tag, "D", 32'(D), 32'(ed));
    cmp(tag, "data", 32'(data), 32'(edat));
    cmp(tag, "row_done", 32'(row_done), 32'(erd));
    cmp(tag, "frame_done", 32'(frame_done), 32'(efd));
  endtask

  // Expected neighbourhood straight from the image coordinates.
  task automatic checkModel(input string tag);
    logic [7:0] ea, eb, ec, ed;
    ea = (my == 0 || mx == 0)     ? 8'd0 : lab[my-1][mx-1];
    eb = (my == 0)                ? 8'd0 : lab[my-1][mx];
    ec = (my == 0 || mx == W - 1) ? 8'd0 : lab[my-1][mx+1];
    ed = (mx == 0)                ? 8'd0 : lab[my][mx-1];
    checkOutput(tag, mx, my, ea, eb, ec, ed, pixel_in, m_rd, m_fd);
  endtask

  task automatic applyStimulus(input bit r, input bit e, input logic [7:0] p,
                               input logic [7:0] l);
    @(negedge clk);
    reset = r; en = e; pixel_in = p; label_in = l;
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset) begin
      mx = 0; my = 0; m_rd = 0; m_fd = 0;
    end else begin
      m_rd = 0; m_fd = 0;
      if (en) begin
        lab[my][mx] = label_in;
        if (mx < W - 1) mx++;
        else begin
          mx = 0; m_rd = 1;
          if (my < H - 1) my++;
          else begin my = 0; m_fd = 1; end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; pixel_in = '0; label_in = '0;
    mx = 0; my = 0; m_rd = 0; m_fd = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) lab[r][c] = 8'd0;

    tbl[0]  = mk(0, 1, 8'h01, 8'd1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 8'h00, 8'd2, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[2]  = mk(0, 1, 8'h11, 8'd3, 2, 0, 0, 0, 0, 2, 0, 0);
    tbl[3]  = mk(0, 1, 8'h22, 8'd4, 3, 0, 0, 0, 0, 3, 0, 0);
    tbl[4]  = mk(0, 1, 8'h01, 8'd9, 0, 1, 0, 1, 2, 0, 1, 0);
    tbl[5]  = mk(0, 1, 8'hFF, 8'd5, 1, 1, 1, 2, 3, 9, 0, 0);
    for (int i = 6; i < 11; i++)
      tbl[i] = mk(0, 0, 8'h00, 8'hEE, 2, 1, 2, 3, 4, 5, 0, 0);
    tbl[11] = mk(0, 1, 8'h00, 8'd6, 2, 1, 2, 3, 4, 5, 0, 0);
    tbl[12] = mk(0, 1, 8'h33, 8'd7, 3, 1, 3, 4, 0, 6, 0, 0);
    tbl[13] = mk(0, 1, 8'h44, 8'd8, 0, 2, 0, 9, 5, 0, 1, 0);

    // Reset held for two cycles with en high.
    applyStimulus(1, 1, 8'h5A, 8'h77); advance();
    applyStimulus(1, 1, 8'h5A, 8'h77); advance();
    applyStimulus(0, 0, 8'h00, 8'h00);
    checkOutput("reset", 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i].r, tbl[i].e, tbl[i].pix, tbl[i].lbl);
      checkOutput($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ea, tbl[i].eb,
                  tbl[i].ec, tbl[i].ed, tbl[i].pix, tbl[i].erd, tbl[i].efd);
      advance();
    end

    // Finish the frame; both pulses land together and the wrap masks the line buffer.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 8'h10, 8'(20 + i));
      checkModel("row2");
      advance();
    end
    applyStimulus(0, 0, 8'h00, 8'h00);
    checkOutput("wrap", 0, 0, 0, 0, 0, 0, 8'h00, 1, 1);
    advance();
    applyStimulus(0, 1, 8'h01, 8'd30);
    checkOutput("wrap_pulse_end", 0, 0, 0, 0, 0, 0, 8'h01, 0, 0);
    advance();

    // Randomized traffic including stalls and occasional resets.
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                    8'($urandom), 8'($urandom_range(1, 255)));
      checkModel("rand");
      advance();
    end

    // Mid-frame reset at (2,1), then the row-0 vectors must repeat exactly.
    begin
      int budget = 40;
      while (!(mx == 2 && my == 1) && budget > 0) begin
        applyStimulus(0, 1, 8'h00, 8'($urandom_range(1, 255)));
        checkModel("seek");
        advance();
        budget--;
      end
      cmp("seek", "reached_2_1", 32'(mx == 2 && my == 1), 32'd1);
    end
    applyStimulus(1, 1, 8'h00, 8'hAB);
    advance();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(tbl[i].r, tbl[i].e, tbl[i].pix, tbl[i].lbl);
      checkOutput($sformatf("post_reset%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ea, tbl[i].eb,
                  tbl[i].ec, tbl[i].ed, tbl[i].pix, tbl[i].erd, tbl[i].efd);
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
